// File: rtl/msg_entry_buffer_pkg.sv
// Shared constants for the HEX message path.
// Character codes, segment patterns and debounce FSM states.
package msg_entry_buffer_pkg;

  localparam logic [2:0] CH_BLANK = 3'd0;
  localparam logic [2:0] CH_D     = 3'd1;
  localparam logic [2:0] CH_E     = 3'd2;
  localparam logic [2:0] CH_1     = 3'd3;

  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DB_PRESS = 3'd1,
    ST_COMMIT   = 3'd2,
    ST_WAIT_REL = 3'd3,
    ST_DB_REL   = 3'd4
  } db_state_t;

endpackage

// File: rtl/msg_entry_buffer_if.sv
// Writer-side bus of the message buffer.
// master drives keys/switches and read index; slave is the buffer.
interface msg_entry_buffer_if #(
  parameter int DEPTH  = 8,
  parameter int CHAR_W = 3
);
  localparam int AW = $clog2(DEPTH);

  logic [CHAR_W-1:0] char_in;
  logic              wr_key_n;
  logic              clr;
  logic [AW-1:0]     rd_addr;
  logic [CHAR_W-1:0] rd_char;
  logic [6:0]        rd_seg;
  logic [AW:0]       len;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              wr_ack;

  modport master (
    output char_in, wr_key_n, clr, rd_addr,
    input  rd_char, rd_seg, len, empty,
    input  full, overflow, wr_ack
  );

  modport slave (
    input  char_in, wr_key_n, clr, rd_addr,
    output rd_char, rd_seg, len, empty,
    output full, overflow, wr_ack
  );

endinterface

// File: rtl/msg_entry_buffer_char_to_seg.sv
// Character code to active-low 7-segment pattern.
// Reserved codes show blank; shared with the scroller.
module char_to_seg #(
  parameter int CHAR_W = 3
) (
  input  logic [CHAR_W-1:0] ch,
  output logic [6:0]        seg
);
  import msg_entry_buffer_pkg::*;

  always_comb begin
    seg = SEG_BLANK;
    unique case (1'b1)
      (ch == CHAR_W'(CH_D)): seg = SEG_D;
      (ch == CHAR_W'(CH_E)): seg = SEG_E;
      (ch == CHAR_W'(CH_1)): seg = SEG_1;
      default:               seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/msg_entry_buffer.sv
// Key-debounced character entry into an append-only message buffer.
// Registered read port feeds the scroller.
module msg_entry_buffer #(
  parameter int DEPTH        = 8,
  parameter int CHAR_W       = 3,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  msg_entry_buffer_if.slave bus
);
  import msg_entry_buffer_pkg::*;

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(DEBOUNCE_CYC - 1);

  logic       s1, s2;
  logic [1:0] fill;
  logic       armed;

  // armed only once a genuine high has come through the
  // synchronizer, so a key held across reset cannot press
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      fill  <= 2'd0;
      armed <= 1'b0;
    end else begin
      s1 <= bus.wr_key_n;
      s2 <= s1;
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (fill == 2'd2 && s2) armed <= 1'b1;
    end
  end

  db_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             cnt_load, cnt_dec, commit;

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    commit   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (armed && !s2) begin
          state_nx = ST_DB_PRESS;
          cnt_load = 1'b1;
        end
      end
      ST_DB_PRESS: begin
        if (s2)            state_nx = ST_IDLE;
        else if (cnt == '0) state_nx = ST_COMMIT;
        else               cnt_dec  = 1'b1;
      end
      ST_COMMIT: begin
        commit   = 1'b1;
        state_nx = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (s2) begin
          state_nx = ST_DB_REL;
          cnt_load = 1'b1;
        end
      end
      ST_DB_REL: begin
        if (!s2)           state_nx = ST_WAIT_REL;
        else if (cnt == '0) state_nx = ST_IDLE;
        else               cnt_dec  = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset)         cnt <= '0;
    else if (cnt_load) cnt <= CNT_INIT;
    else if (cnt_dec)  cnt <= cnt - 1'b1;
  end

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [AW:0]       len;
  logic              ovf;
  logic              full_w;
  logic              wr_en;

  assign full_w = (len == (AW+1)'(DEPTH));
  assign wr_en  = commit && !bus.clr && !full_w;

  // storage is never reset; len gates stale slots
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[len[AW-1:0]] <= bus.char_in;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      len <= '0;
      ovf <= 1'b0;
    end else if (bus.clr) begin
      len <= '0;
      ovf <= 1'b0;
    end else if (commit) begin
      if (full_w) ovf <= 1'b1;
      else        len <= len + 1'b1;
    end
  end

  logic [CHAR_W-1:0] rd_nx;
  logic [6:0]        seg_nx;

  assign rd_nx = ({1'b0, bus.rd_addr} < len)
               ? mem[bus.rd_addr] : '0;

  char_to_seg #(.CHAR_W(CHAR_W)) u_seg (
    .ch  (rd_nx),
    .seg (seg_nx)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bus.rd_char <= '0;
      bus.rd_seg  <= SEG_BLANK;
    end else begin
      bus.rd_char <= rd_nx;
      bus.rd_seg  <= seg_nx;
    end
  end

  assign bus.len      = len;
  assign bus.empty    = (len == '0);
  assign bus.full     = full_w;
  assign bus.overflow = ovf;
  assign bus.wr_ack   = wr_en;

endmodule

// File: tb/tb_msg_entry_buffer.sv
// Bench for msg_entry_buffer with a queue-based message model.
// Directed and randomized presses, bounces, clr and reset cases.
module tb_msg_entry_buffer;

  localparam int DEPTH = 8;
  localparam int DB    = 4;
  localparam int LAT   = 2 + DB + 1;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  msg_entry_buffer_if #(.DEPTH(DEPTH), .CHAR_W(3)) bus ();

  msg_entry_buffer #(
    .DEPTH        (DEPTH),
    .CHAR_W       (3),
    .DEBOUNCE_CYC (DB)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ack_cnt = 0;
  int ack_cyc = -1;

  logic [2:0] model_q [$];
  bit         ovf_m;

  always @(posedge CLOCK_50) cyc++;

  always @(negedge CLOCK_50) begin
    if (bus.wr_ack === 1'b1) begin
      ack_cnt++;
      ack_cyc = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [2:0] c);
    case (c)
      3'd1:    return 7'b0100001;
      3'd2:    return 7'b0000110;
      3'd3:    return 7'b1111001;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk_state();
    int n;
    n = model_q.size();
    chk("len",      32'(bus.len),      32'(n));
    chk("empty",    32'(bus.empty),    32'(n == 0));
    chk("full",     32'(bus.full),     32'(n == DEPTH));
    chk("overflow", 32'(bus.overflow), 32'(ovf_m));
  endtask

  task automatic rd_chk(input int a);
    logic [2:0] e;
    bus.rd_addr = 3'(a);
    step(1);
    e = (a < model_q.size()) ? model_q[a] : 3'd0;
    chk("rd_char", 32'(bus.rd_char), 32'(e));
    chk("rd_seg",  32'(bus.rd_seg),  32'(exp_seg(e)));
  endtask

  // mode 0 clean, 1 bounce on press, 2 bounce on release
  task automatic press(input logic [2:0] ch,
                       input int hold, input int mode);
    int a0, p;
    bit ea;
    a0 = ack_cnt;
    ea = model_q.size() < DEPTH;
    bus.char_in = ch;
    if (mode == 1) begin
      bus.wr_key_n = 1'b0; step(2);
      bus.wr_key_n = 1'b1; step(1);
    end
    bus.wr_key_n = 1'b0;
    p = cyc;
    step(hold);
    if (mode == 2) begin
      bus.wr_key_n = 1'b1; step(2);
      bus.wr_key_n = 1'b0; step(1);
    end
    bus.wr_key_n = 1'b1;
    step(12);
    if (ea) model_q.push_back(ch);
    else    ovf_m = 1'b1;
    chk("ack_count", 32'(ack_cnt - a0), 32'(ea));
    if (ea) chk("ack_latency", 32'(ack_cyc - p), 32'(LAT));
    chk_state();
  endtask

  initial begin
    int a0, p;
    bus.char_in  = 3'd0;
    bus.wr_key_n = 1'b1;
    bus.clr      = 1'b0;
    bus.rd_addr  = 3'd0;
    ovf_m        = 1'b0;

    step(3);
    chk("rst_len",      32'(bus.len),      32'd0);
    chk("rst_empty",    32'(bus.empty),    32'd1);
    chk("rst_full",     32'(bus.full),     32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_wr_ack",   32'(bus.wr_ack),   32'd0);
    chk("rst_rd_char",  32'(bus.rd_char),  32'd0);
    chk("rst_rd_seg",   32'(bus.rd_seg),   32'h7f);
    reset = 1'b0;
    step(6);

    press(3'd1, 10, 0);
    press(3'd2, 10, 0);
    press(3'd3, 10, 0);
    for (int a = 0; a < 4; a++) rd_chk(a);

    press(3'($urandom_range(0, 7)), 10, 1);
    press(3'($urandom_range(1, 3)), 100, 2);
    for (int a = 0; a < DEPTH; a++) rd_chk(a);

    while (model_q.size() < DEPTH)
      press(3'($urandom_range(0, 7)), 9, 0);
    press(3'd2, 9, 0);
    for (int a = 0; a < DEPTH; a++) rd_chk(a);

    bus.clr = 1'b1; step(1); bus.clr = 1'b0;
    model_q.delete(); ovf_m = 1'b0;
    chk_state();
    rd_chk(0);

    press(3'd3, 10, 0);
    press(3'd1, 10, 0);
    a0 = ack_cnt;
    bus.char_in  = 3'd2;
    bus.wr_key_n = 1'b0;
    step(LAT);
    bus.clr = 1'b1; step(1); bus.clr = 1'b0;
    bus.wr_key_n = 1'b1;
    step(12);
    model_q.delete();
    chk("clr_commit_ack", 32'(ack_cnt - a0), 32'd0);
    chk_state();

    press(3'd1, 10, 0);
    a0 = ack_cnt;
    bus.char_in  = 3'd3;
    bus.wr_key_n = 1'b0;
    step(5);
    reset = 1'b1; step(2); reset = 1'b0;
    step(20);
    model_q.delete(); ovf_m = 1'b0;
    chk("held_reset_ack", 32'(ack_cnt - a0), 32'd0);
    chk_state();
    bus.wr_key_n = 1'b1;
    step(12);
    chk("release_ack", 32'(ack_cnt - a0), 32'd0);
    press(3'd3, 10, 0);
    rd_chk(0);

    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        bus.clr = 1'b1; step(1); bus.clr = 1'b0;
        model_q.delete(); ovf_m = 1'b0;
        chk_state();
      end
      press(3'($urandom_range(0, 7)),
            $urandom_range(8, 30),
            $urandom_range(0, 2));
      rd_chk($urandom_range(0, DEPTH - 1));
    end

    p = cyc;
    step(5);
    chk("idle_no_ack", 32'(ack_cyc < p), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
